// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like bus between an instruction and a
// data master. Responses come back in request order, and an in-order owner
// FIFO routes each one to the master that issued it.
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, the grant
// alternates between the two masters whenever both are requesting. When it
// is undefined, the data master always has priority.
module sram_bus_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {ARB_IDLE, ARB_INST, ARB_DATA} arb_state_e;

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rptr, wptr;
  logic [DEPTH-1:0] owner_q, discard_q, slot_valid;
  logic             cancel_pend;
  logic             full, push, pop, push_discard;
`ifdef ARB_ROUND_ROBIN_EN
  logic             last_data;
`endif

  assign full         = (count == CNT_W'(DEPTH));
  assign push         = bus_req && bus_addr_ok;
  assign pop          = resetn && bus_data_ok && (count != '0);
  assign push_discard = (state == ARB_INST) && (inst_cancel || cancel_pend);
  assign inst_data_ok = pop && !owner_q[rptr] && !discard_q[rptr];
  assign data_data_ok = pop && owner_q[rptr];
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: grant from idle only when the owner FIFO has room
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: begin
        if (!full) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (data_req && inst_req) state_nxt = last_data ? ARB_INST : ARB_DATA;
          else if (data_req)        state_nxt = ARB_DATA;
          else if (inst_req)        state_nxt = ARB_INST;
`else
          if (data_req)      state_nxt = ARB_DATA;
          else if (inst_req) state_nxt = ARB_INST;
`endif
        end
      end
      ARB_INST, ARB_DATA: if (bus_addr_ok) state_nxt = ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Bus mux and address handshake from the granted master; held at zero in reset
  always_comb begin
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = '0;
    bus_addr     = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    if (resetn) begin
      unique case (state)
        ARB_INST: begin
          bus_req      = 1'b1;
          bus_wr       = inst_wr;
          bus_size     = inst_size;
          bus_addr     = inst_addr;
          bus_wdata    = inst_wdata;
          inst_addr_ok = bus_addr_ok;
        end
        ARB_DATA: begin
          bus_req      = 1'b1;
          bus_wr       = data_wr;
          bus_size     = data_size;
          bus_addr     = data_addr;
          bus_wdata    = data_wdata;
          data_addr_ok = bus_addr_ok;
        end
        default: ;
      endcase
    end
  end

  // Marks which FIFO slots currently hold outstanding entries
  always_comb begin
    slot_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rptr)) < count;
    end
  end

  // Owner FIFO: push on address accept, pop on response, cancel marks inst entries
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count       <= '0;
      rptr        <= '0;
      wptr        <= '0;
      owner_q     <= '0;
      discard_q   <= '0;
      cancel_pend <= 1'b0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) rptr <= rptr + PTR_W'(1);
      if (inst_cancel) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (slot_valid[i] && !owner_q[i]) discard_q[i] <= 1'b1;
        end
      end
      if (push) begin
        owner_q[wptr]   <= (state == ARB_DATA);
        discard_q[wptr] <= push_discard;
        wptr            <= wptr + PTR_W'(1);
      end
      if (push)                                   cancel_pend <= 1'b0;
      else if (inst_cancel && state == ARB_INST)  cancel_pend <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which master won the previous grant
  always_ff @(posedge clk) begin
    if (!resetn) last_data <= 1'b0;
    else if (state == ARB_IDLE && state_nxt != ARB_IDLE) last_data <= (state_nxt == ARB_DATA);
  end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of grants and outstanding responses.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, inst_cancel;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok;

  always #5 clk = ~clk;

  sram_bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the bus and the queue of outstanding responses
  typedef struct packed {
    logic owner;    // 0 = inst, 1 = data
    logic discard;
  } ent_t;

  ent_t q[$];
  int   gnt;        // 0 none, 1 inst, 2 data
  bit   cancel_seen;
  bit   last_was_data;
  logic e_iaok, e_daok;

  task automatic model_reset();
    q.delete();
    gnt           = 0;
    cancel_seen   = 1'b0;
    last_was_data = 1'b0;
  endtask

  // Called just after a negedge with inputs set; checks outputs, advances model,
  // returns at the following negedge.
  task automatic step();
    logic        e_breq, e_bwr, e_idok, e_ddok, pop, push;
    logic [1:0]  e_bsize;
    logic [31:0] e_baddr, e_bwdata;
    int          sz0;
    ent_t        ent;
    #1;
    e_breq = 0; e_bwr = 0; e_bsize = 0; e_baddr = 0; e_bwdata = 0;
    e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0; pop = 0;
    if (resetn) begin
      if (gnt == 1) begin
        e_breq = 1; e_bwr = inst_wr; e_bsize = inst_size; e_baddr = inst_addr;
        e_bwdata = inst_wdata; e_iaok = bus_addr_ok;
      end else if (gnt == 2) begin
        e_breq = 1; e_bwr = data_wr; e_bsize = data_size; e_baddr = data_addr;
        e_bwdata = data_wdata; e_daok = bus_addr_ok;
      end
      pop = bus_data_ok && (q.size() > 0);
      if (pop) begin
        e_idok = !q[0].owner && !q[0].discard;
        e_ddok = q[0].owner;
      end
    end
    check("bus_req",      32'(bus_req),      32'(e_breq));
    check("bus_wr",       32'(bus_wr),       32'(e_bwr));
    check("bus_size",     32'(bus_size),     32'(e_bsize));
    check("bus_addr",     bus_addr,          e_baddr);
    check("bus_wdata",    bus_wdata,         e_bwdata);
    check("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
    check("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
    check("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
    check("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
    if (e_idok) check("inst_rdata", inst_rdata, bus_rdata);
    if (e_ddok) check("data_rdata", data_rdata, bus_rdata);

    if (!resetn) begin
      model_reset();
    end else begin
      sz0  = q.size();
      push = (gnt != 0) && bus_addr_ok;
      if (pop) void'(q.pop_front());
      if (inst_cancel) foreach (q[i]) if (!q[i].owner) q[i].discard = 1'b1;
      if (push) begin
        ent.owner   = (gnt == 2);
        ent.discard = (gnt == 1) && (inst_cancel || cancel_seen);
        q.push_back(ent);
        cancel_seen = 1'b0;
      end else if (gnt == 1 && inst_cancel) begin
        cancel_seen = 1'b1;
      end
      if (gnt != 0) begin
        if (bus_addr_ok) gnt = 0;
      end else if (sz0 < 4) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (data_req && inst_req) gnt = last_was_data ? 1 : 2;
        else if (data_req)        gnt = 2;
        else if (inst_req)        gnt = 1;
`else
        if (data_req)      gnt = 2;
        else if (inst_req) gnt = 1;
`endif
        if (gnt != 0) last_was_data = (gnt == 2);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    clear_in();
    resetn = 0;
    step();
    step();
    resetn = 1;
  endtask

  logic [3:0] exp_pat;
  bit ih, dh;

  initial begin
    clear_in();
    resetn = 0;
    @(negedge clk);
    do_reset();
    #1;
    check("reset_bus_req", 32'(bus_req), 32'd0);
    check("reset_bus_addr", bus_addr, 32'd0);

    // Single instruction read
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    step();
    bus_addr_ok = 1;
    #1;
    check("r029_addr", bus_addr, 32'hBFC0_0000);
    check("r029_aok", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 0; bus_addr_ok = 0;
    step();
    bus_data_ok = 1; bus_rdata = 32'h2408_0001;
    #1;
    check("r029_dok", 32'(inst_data_ok), 32'd1);
    check("r029_rdata", inst_rdata, 32'h2408_0001);
    check("r029_ddok", 32'(data_data_ok), 32'd0);
    step();

    // Both masters requesting continuously
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_pat = 4'b0101;
`else
    exp_pat = 4'b1111;
`endif
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      check("r030_data_gnt", 32'(data_addr_ok), 32'(exp_pat[k]));
      check("r030_inst_gnt", 32'(inst_addr_ok), 32'(!exp_pat[k]));
      step();
    end

    // Owner FIFO full blocks the fifth grant until a response returns
    do_reset();
    inst_req = 1; bus_addr_ok = 1;
    for (int k = 0; k < 8; k++) step();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("r031_blocked", 32'(bus_req), 32'd0);
      step();
    end
    bus_data_ok = 1;
    step();
    bus_data_ok = 0;
    step();
    #1;
    check("r031_resume", 32'(bus_req), 32'd1);
    step();

    // Cancel discards two inst responses, data response still delivered
    do_reset();
    inst_req = 1; bus_addr_ok = 1;
    for (int k = 0; k < 4; k++) step();
    inst_req = 0; data_req = 1;
    step(); step();
    data_req = 0; bus_addr_ok = 0; inst_cancel = 1;
    step();
    inst_cancel = 0; bus_data_ok = 1;
    for (int k = 0; k < 3; k++) begin
      bus_rdata = 32'h1000 + 32'(k);
      #1;
      check("r032_inst_dok", 32'(inst_data_ok), 32'd0);
      check("r032_data_dok", 32'(data_data_ok), 32'(k == 2));
      step();
    end

    // Reset with outstanding entries drops them
    do_reset();
    inst_req = 1; bus_addr_ok = 1;
    for (int k = 0; k < 6; k++) step();
    do_reset();
    bus_data_ok = 1;
    #1;
    check("r033_inst_dok", 32'(inst_data_ok), 32'd0);
    check("r033_data_dok", 32'(data_data_ok), 32'd0);
    check("r033_idle", 32'(bus_req), 32'd0);
    step();

    // Randomized traffic
    do_reset();
    ih = 0; dh = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!ih) begin
        if ($urandom_range(0, 2) == 0) begin
          ih = 1; inst_req = 1; inst_wr = 1'($urandom_range(0, 1));
          inst_size = 2'($urandom_range(0, 3)); inst_addr = $urandom; inst_wdata = $urandom;
        end else inst_req = 0;
      end
      if (!dh) begin
        if ($urandom_range(0, 2) == 0) begin
          dh = 1; data_req = 1; data_wr = 1'($urandom_range(0, 1));
          data_size = 2'($urandom_range(0, 3)); data_addr = $urandom; data_wdata = $urandom;
        end else data_req = 0;
      end
      bus_addr_ok = ($urandom_range(0, 2) != 0);
      bus_data_ok = ($urandom_range(0, 2) == 0);
      bus_rdata   = $urandom;
      inst_cancel = ($urandom_range(0, 15) == 0);
      resetn      = ($urandom_range(0, 199) != 0);
      step();
      if (e_iaok) ih = 0;
      if (e_daok) dh = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
